// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Access size encodings, lane strobes and alignment rules.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Size 3 is treated as a word access.
  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] offset
  );
    logic ok;
    unique case (1'b1)
      (size == SIZE_B): ok = 1'b1;
      (size == SIZE_H): ok = ~offset[0];
      default:          ok = (offset == 2'd0);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] offset
  );
    logic [3:0] m;
    unique case (1'b1)
      (size == SIZE_B): m = 4'b0001 << offset;
      (size == SIZE_H): m = 4'b0011 << offset;
      default:          m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane strobe, replicated write data and alignment flag.
// Strobe is forced to zero for misaligned accesses.
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  strobe,
  output logic [31:0] lane_data,
  output logic        aligned
);

  assign aligned = is_aligned(size, offset);
  assign strobe  = aligned ? lane_mask(size, offset) : 4'b0000;

  // Replicate the low bytes so every lane sees its slice.
  always_comb begin
    lane_data = wdata;
    unique case (1'b1)
      (size == SIZE_B): lane_data = {4{wdata[7:0]}};
      (size == SIZE_H): lane_data = {2{wdata[15:0]}};
      default:          lane_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Word-organised data RAM with byte-lane writes,
// right-aligned registered reads and sticky misalign tracking.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          Data_addr,
  input  logic [31:0]          Data_out,
  input  logic                 we,
  input  logic [1:0]           wa,
  input  logic                 re,
  input  logic [1:0]           rsize,
  output logic [31:0]          Data_in,
  output logic                 rdata_valid,
  input  logic                 clr_err,
  output logic                 misalign_err,
  output logic [31:0]          err_addr,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    wr_strobe;
  logic [31:0]   wr_data;
  logic          wr_ok;
  logic [3:0]    rd_strobe;
  logic [31:0]   rd_data;
  logic          rd_ok;
  logic [3:0]    wr_en;
  logic [31:0]   cur;
  logic [31:0]   merged;
  logic          evt;
  logic          unused_rd;

  assign idx = Data_addr[AW+1:2];
  assign off = Data_addr[1:0];

  dmem_lane_ctrl u_wr (
    .size      (wa),
    .offset    (off),
    .wdata     (Data_out),
    .strobe    (wr_strobe),
    .lane_data (wr_data),
    .aligned   (wr_ok)
  );

  dmem_lane_ctrl u_rd (
    .size      (rsize),
    .offset    (off),
    .wdata     (32'h0),
    .strobe    (rd_strobe),
    .lane_data (rd_data),
    .aligned   (rd_ok)
  );

  assign unused_rd = ^{rd_strobe, rd_data};

  assign wr_en = we ? wr_strobe : 4'b0000;
  assign cur   = mem[idx];
  assign evt   = (we & ~wr_ok) | (re & ~rd_ok);

  // Post-write view of the word, so a same-cycle read is write-first.
  always_comb begin
    merged = cur;
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  // Byte-lane RAM write; nothing is written while in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Registered read: shifted down, zero for misaligned, held when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_valid <= 1'b0;
      Data_in     <= 32'h0;
    end else begin
      rdata_valid <= re;
      if (re) Data_in <= rd_ok ? (merged >> {off, 3'b000}) : 32'h0;
    end
  end

  // Sticky flag, first-address capture and saturating event count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      err_addr     <= 32'h0;
      err_count    <= '0;
    end else if (evt) begin
      misalign_err <= 1'b1;
      if (!misalign_err || clr_err) err_addr <= Data_addr;
      if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
    end else if (clr_err) begin
      misalign_err <= 1'b0;
      err_addr     <= 32'h0;
    end
  end

endmodule
